// File: rtl/rh_axi4_wr_arbiter.sv
// N-to-1 AXI4 write arbiter: round-robin AW grant, W locked to the winner until WLAST,
// B steered back by the requester index carried in the upper BID bits.
module rh_axi4_wr_arbiter #(
  parameter  int NM        = 4,
  parameter  int AW        = 32,
  parameter  int DW        = 32,
  parameter  int IW        = 4,
  parameter  int MAX_OUTST = 8,
  localparam int GW        = $clog2(NM),
  localparam int OIW       = IW + GW,
  localparam int SW        = DW / 8
) (
  input  logic             ACLK,
  input  logic             ARESET,
  input  logic [NM-1:0]    s_awvalid,
  output logic [NM-1:0]    s_awready,
  input  logic [NM*AW-1:0] s_awaddr,
  input  logic [NM*8-1:0]  s_awlen,
  input  logic [NM*3-1:0]  s_awsize,
  input  logic [NM*2-1:0]  s_awburst,
  input  logic [NM*IW-1:0] s_awid,
  input  logic [NM-1:0]    s_wvalid,
  output logic [NM-1:0]    s_wready,
  input  logic [NM*DW-1:0] s_wdata,
  input  logic [NM*SW-1:0] s_wstrb,
  input  logic [NM-1:0]    s_wlast,
  output logic [NM-1:0]    s_bvalid,
  input  logic [NM-1:0]    s_bready,
  output logic [IW-1:0]    s_bid,
  output logic [1:0]       s_bresp,
  output logic             AWVALID,
  input  logic             AWREADY,
  output logic [AW-1:0]    AWADDR,
  output logic [7:0]       AWLEN,
  output logic [2:0]       AWSIZE,
  output logic [1:0]       AWBURST,
  output logic [OIW-1:0]   AWID,
  output logic             WVALID,
  input  logic             WREADY,
  output logic [DW-1:0]    WDATA,
  output logic [SW-1:0]    WSTRB,
  output logic             WLAST,
  input  logic             BVALID,
  output logic             BREADY,
  input  logic [OIW-1:0]   BID,
  input  logic [1:0]       BRESP,
  output logic             err_bid
);

  // state | meaning
  // IDLE  | waiting for an upstream AW; grants when outstanding count allows
  // ADDR  | presenting the latched AW downstream until AWREADY
  // DATA  | forwarding W from the granted requester until WLAST handshake
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  localparam logic [GW:0] NM_W   = (GW+1)'(NM);
  localparam logic [7:0]  MAXO_W = 8'(MAX_OUTST);

  state_t          state, state_nxt;
  logic [GW-1:0]   rr_ptr, g_reg, gsel, cand;
  logic [GW:0]     cand_sum;
  logic            found, grant;
  logic [7:0]      outst;
  logic [GW-1:0]   bidx;
  logic            bidx_ok, aw_hs, b_hs;
  logic [AW-1:0]   awaddr_r;
  logic [7:0]      awlen_r;
  logic [2:0]      awsize_r;
  logic [1:0]      awburst_r;
  logic [OIW-1:0]  awid_r;

  // Scan from rr_ptr upward; iterating downward lets the nearest candidate win.
  always_comb begin
    found    = 1'b0;
    gsel     = '0;
    cand_sum = '0;
    cand     = '0;
    for (int k = NM-1; k >= 0; k--) begin
      cand_sum = {1'b0, rr_ptr} + (GW+1)'(k);
      if (cand_sum >= NM_W) cand_sum = cand_sum - NM_W;
      cand = cand_sum[GW-1:0];
      if (s_awvalid[cand]) begin
        found = 1'b1;
        gsel  = cand;
      end
    end
  end

  assign grant = (state == IDLE) && found && (outst < MAXO_W) && !ARESET;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant) state_nxt = ADDR;
      ADDR:    if (AWREADY) state_nxt = DATA;
      DATA:    if (s_wvalid[g_reg] && WREADY && s_wlast[g_reg]) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    s_awready = '0;
    s_wready  = '0;
    AWVALID   = 1'b0;
    WVALID    = 1'b0;
    WDATA     = s_wdata[g_reg*DW +: DW];
    WSTRB     = s_wstrb[g_reg*SW +: SW];
    WLAST     = s_wlast[g_reg];
    if (grant) s_awready[gsel] = 1'b1;
    if (state == ADDR) AWVALID = 1'b1;
    if (state == DATA) begin
      WVALID          = s_wvalid[g_reg];
      s_wready[g_reg] = WREADY;
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rr_ptr    <= '0;
      g_reg     <= '0;
      awaddr_r  <= '0;
      awlen_r   <= '0;
      awsize_r  <= '0;
      awburst_r <= '0;
      awid_r    <= '0;
    end else if (grant) begin
      g_reg     <= gsel;
      rr_ptr    <= (gsel == GW'(NM-1)) ? '0 : gsel + 1'b1;
      awaddr_r  <= s_awaddr[gsel*AW +: AW];
      awlen_r   <= s_awlen[gsel*8 +: 8];
      awsize_r  <= s_awsize[gsel*3 +: 3];
      awburst_r <= s_awburst[gsel*2 +: 2];
      awid_r    <= {gsel, s_awid[gsel*IW +: IW]};
    end
  end

  assign AWADDR  = awaddr_r;
  assign AWLEN   = awlen_r;
  assign AWSIZE  = awsize_r;
  assign AWBURST = awburst_r;
  assign AWID    = awid_r;

  // Responses carrying an index with no requester behind it are sunk here.
  assign bidx    = BID[OIW-1:IW];
  assign bidx_ok = {1'b0, bidx} < NM_W;
  assign s_bid   = BID[IW-1:0];
  assign s_bresp = BRESP;

  always_comb begin
    s_bvalid = '0;
    BREADY   = 1'b1;
    for (int i = 0; i < NM; i++) begin
      if (bidx == GW'(i)) begin
        s_bvalid[i] = BVALID;
        BREADY      = s_bready[i];
      end
    end
  end

  assign aw_hs = AWVALID && AWREADY;
  assign b_hs  = BVALID && BREADY && bidx_ok && (outst != 8'd0);

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      outst   <= '0;
      err_bid <= 1'b0;
    end else begin
      if (aw_hs && !b_hs)      outst <= outst + 8'd1;
      else if (!aw_hs && b_hs) outst <= outst - 8'd1;
      if (BVALID && !bidx_ok) err_bid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rh_axi4_wr_arbiter.sv
// Scoreboard bench for rh_axi4_wr_arbiter. NM=3 so that an out-of-range BID index
// is encodable; MAX_OUTST=2 to exercise the grant throttle.
module tb_rh_axi4_wr_arbiter;
  localparam int NM = 3, AW = 32, DW = 32, IW = 4, MO = 2, GW = 2, OIW = 6, SW = 4;

  logic ACLK = 1'b0;
  logic ARESET;
  always #5 ACLK = ~ACLK;

  logic [NM-1:0]    s_awvalid, s_awready, s_wvalid, s_wready, s_wlast, s_bvalid, s_bready;
  logic [NM*AW-1:0] s_awaddr;
  logic [NM*8-1:0]  s_awlen;
  logic [NM*3-1:0]  s_awsize;
  logic [NM*2-1:0]  s_awburst;
  logic [NM*IW-1:0] s_awid;
  logic [NM*DW-1:0] s_wdata;
  logic [NM*SW-1:0] s_wstrb;
  logic [IW-1:0]    s_bid;
  logic [1:0]       s_bresp, AWBURST, BRESP;
  logic             AWVALID, AWREADY, WVALID, WREADY, WLAST, BVALID, BREADY, err_bid;
  logic [AW-1:0]    AWADDR;
  logic [7:0]       AWLEN;
  logic [2:0]       AWSIZE;
  logic [OIW-1:0]   AWID, BID;
  logic [DW-1:0]    WDATA;
  logic [SW-1:0]    WSTRB;

  bit             auto_b;
  logic           auto_bvalid, man_bvalid;
  logic [OIW-1:0] auto_bid, man_bid;
  logic [1:0]     man_bresp;
  assign BVALID = auto_b ? auto_bvalid : man_bvalid;
  assign BID    = auto_b ? auto_bid : man_bid;
  assign BRESP  = auto_b ? 2'b00 : man_bresp;

  rh_axi4_wr_arbiter #(.NM(NM), .AW(AW), .DW(DW), .IW(IW), .MAX_OUTST(MO)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awlen(s_awlen),
    .s_awsize(s_awsize), .s_awburst(s_awburst), .s_awid(s_awid),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bid(s_bid), .s_bresp(s_bresp),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
    .AWBURST(AWBURST), .AWID(AWID),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST),
    .BVALID(BVALID), .BREADY(BREADY), .BID(BID), .BRESP(BRESP), .err_bid(err_bid)
  );

  int total = 0, passed = 0;
  logic [63:0]    exp_aw[$], exp_w[$], exp_b[$];
  logic [OIW-1:0] bq[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
  endtask

  task automatic fail_note(input string name);
    total++;
    $display("FAIL %s: got nothing/unexpected want expected event", name);
  endtask

  function automatic logic [63:0] aw_pk(input logic [OIW-1:0] id, input logic [31:0] a, input logic [7:0] l);
    return {13'b0, id, a, l, 3'd2, 2'd1};
  endfunction
  function automatic logic [63:0] w_pk(input logic [31:0] d, input logic l);
    return {27'b0, d, 4'hF, l};
  endfunction
  function automatic logic [63:0] b_pk(input logic [3:0] i, input logic [3:0] id, input logic [1:0] r);
    return {54'b0, i, id, r};
  endfunction

  // Monitor: compares every downstream AW/W and upstream B handshake against the queues.
  initial forever begin
    @(negedge ACLK);
    if (!ARESET) begin
      if (AWVALID && AWREADY) begin
        if (exp_aw.size() == 0) fail_note("aw_unexpected");
        else check("aw", {13'b0, AWID, AWADDR, AWLEN, AWSIZE, AWBURST}, exp_aw.pop_front());
        if (auto_b) bq.push_back(AWID);
      end
      if (WVALID && WREADY) begin
        if (exp_w.size() == 0) fail_note("w_unexpected");
        else check("w", {27'b0, WDATA, WSTRB, WLAST}, exp_w.pop_front());
      end
      for (int i = 0; i < NM; i++) begin
        if (s_bvalid[i] && s_bready[i]) begin
          if (exp_b.size() == 0) fail_note("b_unexpected");
          else check("b", b_pk(4'(i), s_bid, s_bresp), exp_b.pop_front());
        end
      end
    end
  end

  // Downstream slave answering accepted AWs in order with OKAY.
  initial begin
    bit hs;
    auto_bvalid = 1'b0;
    auto_bid    = '0;
    forever begin
      @(negedge ACLK);
      hs = auto_b && auto_bvalid && BREADY;
      @(posedge ACLK); #1;
      if (hs) begin
        bq.delete(0);
        auto_bvalid = 1'b0;
      end
      if (auto_b && !auto_bvalid && bq.size() > 0) begin
        auto_bvalid = 1'b1;
        auto_bid    = bq[0];
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge ACLK); #1;
  endtask

  task automatic set_aw(input int r, input logic v, input logic [31:0] a, input logic [7:0] l, input logic [3:0] id);
    s_awvalid[r]          = v;
    s_awaddr[r*AW +: AW]  = a;
    s_awlen[r*8 +: 8]     = l;
    s_awsize[r*3 +: 3]    = 3'd2;
    s_awburst[r*2 +: 2]   = 2'd1;
    s_awid[r*IW +: IW]    = id;
  endtask

  task automatic send_w(input int r, input logic [31:0] d, input logic last);
    int n = 0;
    exp_w.push_back(w_pk(d, last));
    s_wvalid[r]          = 1'b1;
    s_wdata[r*DW +: DW]  = d;
    s_wstrb[r*SW +: SW]  = 4'hF;
    s_wlast[r]           = last;
    @(negedge ACLK);
    while (!s_wready[r] && n < 50) begin
      @(negedge ACLK);
      n++;
    end
    if (n >= 50) fail_note("w_wait");
    tick;
    s_wvalid[r] = 1'b0;
    s_wlast[r]  = 1'b0;
  endtask

  task automatic wait_grant(input int r, input string name);
    int n = 0;
    @(negedge ACLK);
    while (!s_awready[r] && n < 50) begin
      @(negedge ACLK);
      n++;
    end
    check(name, s_awready, 3'b001 << r);
  endtask

  initial begin
    int grants, n;
    ARESET = 1'b1;
    s_awvalid = '0; s_awaddr = '0; s_awlen = '0; s_awsize = '0; s_awburst = '0; s_awid = '0;
    s_wvalid = '0; s_wdata = '0; s_wstrb = '0; s_wlast = '0; s_bready = '1;
    AWREADY = 1'b1; WREADY = 1'b1;
    auto_b = 1'b0; man_bvalid = 1'b0; man_bid = '0; man_bresp = '0;
    set_aw(2, 1'b1, 32'h100, 8'd3, 4'hA);
    repeat (2) @(posedge ACLK);
    @(negedge ACLK);
    check("rst_awvalid", AWVALID, 0);
    check("rst_wvalid", WVALID, 0);
    check("rst_awready", s_awready, 0);
    check("rst_wready", s_wready, 0);
    check("rst_errbid", err_bid, 0);
    check("rst_aw_payload", {AWID, AWADDR, AWLEN}, 0);
    tick;
    ARESET = 1'b0;

    // single requester, 4-beat burst
    @(negedge ACLK);
    check("t1_grant", s_awready, 3'b100);
    exp_aw.push_back(aw_pk({2'd2, 4'hA}, 32'h100, 8'd3));
    tick;
    s_awvalid[2] = 1'b0;
    s_wvalid[2] = 1'b1;
    s_wdata[2*DW +: DW] = 32'hD0;
    s_wstrb[2*SW +: SW] = 4'hF;
    @(negedge ACLK);
    check("t1_aw_latency", AWVALID, 1);
    check("t1_w_blocked_in_addr", {WVALID, s_wready}, 0);
    tick;
    for (int b = 0; b < 4; b++) send_w(2, 32'hD0 + 32'(b), b == 3);
    @(negedge ACLK);
    check("t1_back_idle", {AWVALID, WVALID}, 0);
    tick;
    man_bvalid = 1'b1; man_bid = {2'd2, 4'hA}; man_bresp = 2'b01; s_bready = 3'b011;
    @(negedge ACLK);
    check("t1_bvalid_route", s_bvalid, 3'b100);
    check("t1_bready_follow", BREADY, 0);
    tick;
    s_bready = 3'b111;
    exp_b.push_back(b_pk(4'd2, 4'hA, 2'b01));
    @(negedge ACLK);
    check("t1_bready", BREADY, 1);
    tick;
    man_bvalid = 1'b0;

    // all requesters busy, single-beat bursts: round-robin 0,1,2,0,1,2
    auto_b = 1'b1;
    for (int i = 0; i < NM; i++) begin
      set_aw(i, 1'b1, 32'h1000 + 32'(16*i), 8'd0, 4'(i+1));
      s_wvalid[i] = 1'b1;
      s_wlast[i]  = 1'b1;
      s_wdata[i*DW +: DW] = 32'hA0 + 32'(i);
      s_wstrb[i*SW +: SW] = 4'hF;
    end
    for (int k = 0; k < 6; k++) begin
      exp_aw.push_back(aw_pk({2'(k%3), 4'(k%3+1)}, 32'h1000 + 32'(16*(k%3)), 8'd0));
      exp_w.push_back(w_pk(32'hA0 + 32'(k%3), 1'b1));
      exp_b.push_back(b_pk(4'(k%3), 4'(k%3+1), 2'b00));
    end
    grants = 0; n = 0;
    while (grants < 6 && n < 200) begin
      @(negedge ACLK);
      if (s_awready != 0) grants++;
      tick;
      n++;
    end
    s_awvalid = '0;
    check("t2_grants", grants, 6);
    n = 0;
    while ((exp_aw.size() + exp_w.size() + exp_b.size() + bq.size()) != 0 && n < 200) begin
      tick;
      n++;
    end
    check("t2_drain", exp_aw.size() + exp_w.size() + exp_b.size() + bq.size(), 0);
    tick;
    auto_b = 1'b0;
    s_wvalid = '0;
    s_wlast = '0;

    // downstream stalls AW for 5 cycles
    AWREADY = 1'b0;
    set_aw(1, 1'b1, 32'h2000, 8'd0, 4'd3);
    @(negedge ACLK);
    check("t3_grant1", s_awready, 3'b010);
    exp_aw.push_back(aw_pk({2'd1, 4'd3}, 32'h2000, 8'd0));
    tick;
    s_awvalid[1] = 1'b0;
    set_aw(0, 1'b1, 32'h3000, 8'd0, 4'd5);
    for (int c = 0; c < 5; c++) begin
      @(negedge ACLK);
      check("t3_aw_hold", {AWVALID, AWADDR}, {1'b1, 32'h2000});
      check("t3_no_grant", s_awready, 0);
      tick;
    end
    AWREADY = 1'b1;
    send_w(1, 32'h11, 1'b1);
    exp_aw.push_back(aw_pk({2'd0, 4'd5}, 32'h3000, 8'd0));
    wait_grant(0, "t3_grant0");
    tick;
    s_awvalid[0] = 1'b0;
    send_w(0, 32'h22, 1'b1);

    // two writes outstanding, no B yet: third AW must wait
    set_aw(2, 1'b1, 32'h4000, 8'd0, 4'd7);
    for (int c = 0; c < 4; c++) begin
      @(negedge ACLK);
      check("t4_block", s_awready, 0);
      tick;
    end
    AWREADY = 1'b0;
    man_bvalid = 1'b1; man_bid = {2'd1, 4'd3}; man_bresp = 2'b00;
    exp_b.push_back(b_pk(4'd1, 4'd3, 2'b00));
    @(negedge ACLK);
    check("t4_block_during_b", s_awready, 0);
    tick;
    man_bvalid = 1'b0;
    @(negedge ACLK);
    check("t4_grant2", s_awready, 3'b100);
    exp_aw.push_back(aw_pk({2'd2, 4'd7}, 32'h4000, 8'd0));
    tick;
    s_awvalid[2] = 1'b0;

    // AW and B handshakes in the same cycle leave the count unchanged
    man_bvalid = 1'b1; man_bid = {2'd0, 4'd5}; man_bresp = 2'b10;
    exp_b.push_back(b_pk(4'd0, 4'd5, 2'b10));
    AWREADY = 1'b1;
    @(negedge ACLK);
    check("t5_same_cycle", {AWVALID, AWREADY, BVALID, BREADY}, 4'hF);
    tick;
    man_bvalid = 1'b0;
    send_w(2, 32'h33, 1'b1);
    set_aw(0, 1'b1, 32'h5000, 8'd0, 4'd9);
    set_aw(1, 1'b1, 32'h6000, 8'd3, 4'd1);
    exp_aw.push_back(aw_pk({2'd0, 4'd9}, 32'h5000, 8'd0));
    wait_grant(0, "t5_one_more_grant");
    tick;
    s_awvalid[0] = 1'b0;
    send_w(0, 32'h44, 1'b1);
    for (int c = 0; c < 3; c++) begin
      @(negedge ACLK);
      check("t5_block_again", s_awready, 0);
      tick;
    end

    // out-of-range BID index is dropped and flagged
    man_bvalid = 1'b1; man_bid = {2'd3, 4'd1}; man_bresp = 2'b00;
    @(negedge ACLK);
    check("t6_drop_bready", BREADY, 1);
    check("t6_no_bvalid", s_bvalid, 0);
    tick;
    man_bvalid = 1'b0;
    @(negedge ACLK);
    check("t6_err_bid", err_bid, 1);
    check("t6_no_decrement", s_awready, 0);
    tick;
    man_bvalid = 1'b1; man_bid = {2'd2, 4'd7}; man_bresp = 2'b11;
    exp_b.push_back(b_pk(4'd2, 4'd7, 2'b11));
    @(negedge ACLK);
    tick;
    man_bvalid = 1'b0;
    exp_aw.push_back(aw_pk({2'd1, 4'd1}, 32'h6000, 8'd3));
    wait_grant(1, "t6_grant1");
    tick;
    s_awvalid[1] = 1'b0;
    send_w(1, 32'h55, 1'b0);

    // reset in the middle of the burst
    AWREADY = 1'b0;
    s_awvalid = 3'b011;
    s_wvalid[1] = 1'b1;
    ARESET = 1'b1;
    @(negedge ACLK);
    check("t6_rst_awvalid", AWVALID, 0);
    check("t6_rst_w", {WVALID, s_wready}, 0);
    check("t6_rst_err_bid", err_bid, 0);
    check("t6_rst_awready", s_awready, 0);
    tick;
    ARESET = 1'b0;
    @(negedge ACLK);
    check("t6_rr_ptr_reset", s_awready, 3'b001);
    tick;
    s_awvalid = '0;
    s_wvalid = '0;
    check("final_queues", exp_aw.size() + exp_w.size() + exp_b.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
